// File: rtl/bgr_startup_ctrl.sv
// Bandgap reference start-up sequencer and health monitor behind a Wishbone slave:
// pulses porst, waits to settle, qualifies vbg_ok, retries on fault and raises irq.
module bgr_startup_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [15:0] TIMEOUT   = 16'd1000,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        vbg_ok_i,
  output logic        porst_o,
  output logic        bgr_ready_o,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PORST  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_READY  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [2:0] MAX_RETRY_W = 3'(MAX_RETRY);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] lim_reg, lim_next;
  logic [1:0]  run_reg, run_next;
  logic [2:0]  retry_reg, retry_next;
  logic [2:0]  evt;

  logic        ok_meta, ok_s;
  logic        en_reg;
  logic [23:0] cfg_reg;
  logic [2:0]  flags_reg;

  logic        hit, wr;
  logic [1:0]  reg_idx;
  logic        restart;
  logic [2:0]  flag_clr;
  logic [15:0] porst_len;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ok_meta <= 1'b0;
      ok_s    <= 1'b0;
    end else begin
      ok_meta <= vbg_ok_i;
      ok_s    <= ok_meta;
    end
  end

  // A request is only taken while ack is low, so each transaction sees exactly one ack.
  assign hit     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign reg_idx = wbs_adr_i[3:2];
  assign wr      = hit & wbs_we_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign restart = wr & (reg_idx == 2'd0) & wbs_sel_i[0] & wbs_dat_i[1] & wbs_dat_i[0];
  assign flag_clr = (wr && reg_idx == 2'd3 && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;
  assign porst_len = (cfg_reg[23:16] == 8'd0) ? 16'd1 : {8'd0, cfg_reg[23:16]};

  always_comb begin
    rd_data = 32'd0;
    case (reg_idx)
      2'd0: rd_data = {31'd0, en_reg};
      2'd1: rd_data = {8'd0, cfg_reg};
      2'd2: rd_data = {24'd0, bgr_ready_o, ok_s, retry_reg, state_reg};
      default: rd_data = {29'd0, flags_reg};
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
      en_reg    <= 1'b0;
      cfg_reg   <= 24'h10_0100;
      flags_reg <= 3'b000;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit && !wbs_we_i && wbs_adr_i[31:4] == BASE_ADDR[31:4]) ? rd_data : 32'd0;
      if (wr && reg_idx == 2'd0 && wbs_sel_i[0]) en_reg <= wbs_dat_i[0];
      if (wr && reg_idx == 2'd1) begin
        for (int b = 0; b < 3; b++) begin
          if (wbs_sel_i[b]) cfg_reg[8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
      // Set beats clear when a W1C write lands on the same cycle as an event.
      flags_reg <= (flags_reg & ~flag_clr) | evt;
    end
  end

  assign irq_o = |flags_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lim_next   = lim_reg;
    run_next   = run_reg;
    retry_next = retry_reg;
    evt        = 3'b000;
    if (restart) begin
      state_next = S_PORST;
      cnt_next   = 16'd0;
      lim_next   = porst_len;
      retry_next = 3'd0;
      run_next   = 2'd0;
    end else if (!en_reg) begin
      state_next = S_IDLE;
      cnt_next   = 16'd0;
      run_next   = 2'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_PORST;
          cnt_next   = 16'd0;
          lim_next   = porst_len;
        end
        S_PORST: begin
          if (cnt_reg == lim_reg - 16'd1) begin
            state_next = S_SETTLE;
            cnt_next   = 16'd0;
            lim_next   = cfg_reg[15:0];
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
        S_SETTLE: begin
          if (lim_reg == 16'd0 || cnt_reg == lim_reg - 16'd1) begin
            state_next = S_CHECK;
            cnt_next   = 16'd0;
            run_next   = 2'd0;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
        S_CHECK: begin
          // run_reg counts earlier consecutive highs; the fourth high qualifies.
          if (ok_s && run_reg == 2'd3) begin
            state_next = S_READY;
            run_next   = 2'd0;
            evt[0]     = 1'b1;
          end else begin
            run_next = ok_s ? run_reg + 2'd1 : 2'd0;
            if (cnt_reg == TIMEOUT - 16'd1) begin
              state_next = S_FAULT;
              evt[1]     = 1'b1;
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end
        end
        S_READY: begin
          if (!ok_s && run_reg == 2'd3) begin
            state_next = S_FAULT;
            run_next   = 2'd0;
            evt[2]     = 1'b1;
          end else begin
            run_next = ok_s ? 2'd0 : run_reg + 2'd1;
          end
        end
        S_FAULT: begin
          if (retry_reg < MAX_RETRY_W) begin
            retry_next = retry_reg + 3'd1;
            state_next = S_PORST;
            cnt_next   = 16'd0;
            lim_next   = porst_len;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 16'd0;
      lim_reg     <= 16'd1;
      run_reg     <= 2'd0;
      retry_reg   <= 3'd0;
      porst_o     <= 1'b1;
      bgr_ready_o <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      lim_reg     <= lim_next;
      run_reg     <= run_next;
      retry_reg   <= retry_next;
      porst_o     <= (state_next == S_IDLE) || (state_next == S_PORST) || (state_next == S_FAULT);
      bgr_ready_o <= (state_next == S_READY);
    end
  end

endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Self-checking bench for bgr_startup_ctrl: directed sequences plus randomized
// vbg_ok / Wishbone traffic compared every cycle against a phase-level model.
module tb_bgr_startup_ctrl;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int TMO  = 60;
  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = 32'd0, adr = 32'd0;
  logic        ack;
  logic [31:0] rdat;
  logic        vbg = 1'b0;
  logic        porst, ready, irq;

  always #5 clk = ~clk;

  bgr_startup_ctrl #(.BASE_ADDR(BASE), .TIMEOUT(16'(TMO)), .MAX_RETRY(MAXR)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .vbg_ok_i(vbg), .porst_o(porst), .bgr_ready_o(ready), .irq_o(irq)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Model: phase = 0 idle,1 porst,2 settle,3 check,4 ready,5 fault; rem counts cycles left.
  int          m_state, m_retry, m_rem, m_hi, m_lo;
  bit          m_en, m_ok1, m_oks, m_ack;
  logic [23:0] m_cfg;
  logic [2:0]  m_flags;
  logic [31:0] m_dat;

  task automatic model_reset();
    m_state = 0; m_retry = 0; m_rem = 0; m_hi = 0; m_lo = 0;
    m_en = 0; m_ok1 = 0; m_oks = 0; m_ack = 0;
    m_cfg = 24'h10_0100; m_flags = 3'b000; m_dat = 32'd0;
  endtask

  function automatic int porst_len(input logic [23:0] c);
    return (c[23:16] == 8'd0) ? 1 : int'(c[23:16]);
  endfunction

  function automatic logic [31:0] reg_view(input logic [1:0] idx);
    case (idx)
      2'd0: return {31'd0, m_en};
      2'd1: return {8'd0, m_cfg};
      2'd2: return {24'd0, 1'(m_state == 4), m_oks, 3'(m_retry), 3'(m_state)};
      default: return {29'd0, m_flags};
    endcase
  endfunction

  task automatic model_edge();
    logic match, hit, wr, restart;
    logic [1:0] idx;
    logic [2:0] evt, clr;
    logic [31:0] dnext;
    match = (adr[31:4] == BASE[31:4]);
    hit = cyc && stb && !m_ack;
    idx = adr[3:2];
    dnext = (hit && match && !we) ? reg_view(idx) : 32'd0;
    wr = hit && match && we;
    restart = wr && idx == 2'd0 && sel[0] && wdat[1] && wdat[0];
    clr = (wr && idx == 2'd3 && sel[0]) ? wdat[2:0] : 3'b000;
    evt = 3'b000;
    if (restart) begin
      m_state = 1; m_retry = 0; m_rem = porst_len(m_cfg);
    end else if (!m_en) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_rem = porst_len(m_cfg); end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_state = 2;
            m_rem = (m_cfg[15:0] == 16'd0) ? 1 : int'(m_cfg[15:0]);
          end
        end
        2: begin
          m_rem--;
          if (m_rem == 0) begin m_state = 3; m_rem = TMO; m_hi = 0; end
        end
        3: begin
          m_hi = m_oks ? m_hi + 1 : 0;
          if (m_hi == 4) begin
            m_state = 4; m_lo = 0; evt[0] = 1'b1;
          end else begin
            m_rem--;
            if (m_rem == 0) begin m_state = 5; evt[1] = 1'b1; end
          end
        end
        4: begin
          m_lo = m_oks ? 0 : m_lo + 1;
          if (m_lo == 4) begin m_state = 5; evt[2] = 1'b1; end
        end
        default: begin
          if (m_retry < MAXR) begin
            m_retry++; m_state = 1; m_rem = porst_len(m_cfg);
          end
        end
      endcase
    end
    if (wr && idx == 2'd0 && sel[0]) m_en = wdat[0];
    if (wr && idx == 2'd1)
      for (int b = 0; b < 3; b++)
        if (sel[b]) m_cfg[8*b +: 8] = wdat[8*b +: 8];
    m_flags = (m_flags & ~clr) | evt;
    m_oks = m_ok1;
    m_ok1 = vbg;
    m_ack = hit;
    m_dat = dnext;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("porst", 32'(porst), 32'(m_state == 0 || m_state == 1 || m_state == 5));
    check("ready", 32'(ready), 32'(m_state == 4));
    check("irq", 32'(irq), 32'(m_flags != 3'b000));
    check("ack", 32'(ack), 32'(m_ack));
    check("rdata", rdat, m_dat);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d; sel = s;
    step();
    step();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("WR adr=%h dat=%h sel=%b", a, d, s);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hf;
    step();
    d = rdat;
    step();
    cyc = 1'b0; stb = 1'b0;
    $display("RD adr=%h dat=%h", a, d);
  endtask

  initial begin
    logic [31:0] rd;
    int fall_at, rise_at, guard, hold;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_porst", 32'(porst), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_read(BASE + 0, rd);  check("rst_ctrl", rd, 32'd0);
    wb_read(BASE + 4, rd);  check("rst_cfg", rd, 32'h0010_0100);
    wb_read(BASE + 8, rd);  check("rst_status", rd, 32'd0);
    wb_read(BASE + 12, rd); check("rst_flags", rd, 32'd0);

    // Nominal start-up: 16 settle cycles then 4 qualifying CHECK cycles.
    vbg = 1'b1;
    wb_write(BASE + 4, 32'h0004_0010, 4'hf);
    wb_write(BASE + 0, 32'd1, 4'hf);
    fall_at = -1; rise_at = -1;
    for (int i = 0; i < 200 && rise_at < 0; i++) begin
      step();
      if (fall_at < 0 && !porst) fall_at = i;
      if (ready) rise_at = i;
    end
    check("settle_to_ready", 32'(rise_at - fall_at), 32'd20);
    check("ready_irq", 32'(irq), 32'd1);
    wb_read(BASE + 12, rd); check("ready_flags", rd, 32'd1);

    // 3-cycle glitch ignored, then a real loss of the reference.
    vbg = 1'b0; repeat (3) step();
    vbg = 1'b1; repeat (6) step();
    check("glitch_ready", 32'(ready), 32'd1);
    vbg = 1'b0; repeat (8) step();
    wb_read(BASE + 8, rd); check("lost_retry", 32'(rd[5:3]), 32'd1);
    wb_read(BASE + 12, rd); check("lost_flag", 32'(rd[2]), 32'd1);

    // Reference never comes up: retries exhaust, then FAULT latches.
    wb_write(BASE + 0, 32'd3, 4'hf);
    repeat (400) step();
    wb_read(BASE + 8, rd); check("latched_fault", 32'(rd[7:0]), 32'h15);
    wb_write(BASE + 12, 32'd7, 4'hf);
    check("w1c_irq", 32'(irq), 32'd0);
    wb_read(BASE + 12, rd); check("w1c_flags", rd, 32'd0);
    wb_write(BASE + 0, 32'd3, 4'hf);
    wb_read(BASE + 8, rd); check("restart_status", 32'(rd[7:0]), 32'h01);

    // W1C landing on the same edge as ready_evt.
    vbg = 1'b1;
    guard = 0;
    while (!(m_state == 3 && m_oks && m_hi == 3) && guard < 300) begin step(); guard++; end
    check("wait_qualify", 32'(guard < 300), 32'd1);
    wb_write(BASE + 12, 32'd7, 4'hf);
    wb_read(BASE + 12, rd); check("w1c_vs_evt", rd, 32'd1);

    // Reset in the middle of SETTLE.
    wb_write(BASE + 4, 32'h0004_0100, 4'hf);
    wb_write(BASE + 0, 32'd3, 4'hf);
    guard = 0;
    while (m_state != 2 && guard < 100) begin step(); guard++; end
    check("wait_settle", 32'(guard < 100), 32'd1);
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_porst", 32'(porst), 32'd1);
    check("mid_rst_ready", 32'(ready), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_dat", rdat, 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    wb_read(BASE + 0, rd); check("post_rst_ctrl", rd, 32'd0);
    wb_read(BASE + 4, rd); check("post_rst_cfg", rd, 32'h0010_0100);

    // Bus corner cases.
    wb_read(BASE + 8, rd);
    wb_read(BASE + 8, rd);
    wb_read(32'h4000_0008, rd); check("off_base", rd, 32'd0);
    wb_write(BASE + 4, 32'hAABB_CCDD, 4'b0001);
    wb_read(BASE + 4, rd); check("byte_sel", rd, 32'h0010_01DD);

    // Randomized traffic.
    hold = 0;
    for (int it = 0; it < 4000; it++) begin
      if (hold == 0) begin
        vbg = ($urandom_range(0, 2) != 0);
        hold = vbg ? int'($urandom_range(4, 60)) : int'($urandom_range(1, 8));
      end
      hold--;
      if ($urandom_range(0, 19) != 0) begin
        step();
      end else begin
        case ($urandom_range(0, 6))
          0, 1, 2: begin
            if ($urandom_range(0, 7) == 0) wb_read($urandom, rd);
            else wb_read(BASE + {28'd0, 2'($urandom_range(0, 3)), 2'b00}, rd);
          end
          3: wb_write(BASE + 4, {8'd0, 8'($urandom_range(0, 6)), 16'($urandom_range(0, 30))},
                      4'($urandom));
          4: wb_write(BASE + 0, {30'd0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0)},
                      4'hf);
          5: wb_write(BASE + 12, $urandom, 4'($urandom));
          default: wb_write($urandom & 32'hFFFF_FFFC, $urandom, 4'hf);
        endcase
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
